// File: rtl/dsp_mac_sequencer_if.sv
// Operand handshake and DSP48A1 pipeline-control bundle for dsp_mac_sequencer.
//   start, len, in_valid   : operand source -> sequencer (run request, pair count, pair valid)
//   in_ready               : sequencer -> operand source (pair accepted this cycle when valid)
//   ce_ab, ce_m, ce_p      : clock enables for the A/B, M and P pipeline registers
//   rst_p                  : synchronous reset strobe for the P register
//   opmode                 : DSP48A1 OPMODE
//   busy, result_valid, done : run status
// The sequencer connects through the slave modport; the source/slice side uses master.
interface dsp_mac_sequencer_if #(
    parameter int unsigned CNT_W = 8
);
    logic             start;
    logic [CNT_W-1:0] len;
    logic             in_valid;
    logic             in_ready;
    logic             ce_ab;
    logic             ce_m;
    logic             ce_p;
    logic             rst_p;
    logic [7:0]       opmode;
    logic             busy;
    logic             result_valid;
    logic             done;

    modport master (
        output start, len, in_valid,
        input  in_ready, ce_ab, ce_m, ce_p, rst_p, opmode, busy, result_valid, done
    );

    modport slave (
        input  start, len, in_valid,
        output in_ready, ce_ab, ce_m, ce_p, rst_p, opmode, busy, result_valid, done
    );
endinterface

// File: rtl/dsp_mac_sequencer.sv
// Sequencer driving the DSP48A1 pipeline-register strobes for a multiply-accumulate
// over a programmed number of operand pairs.
//   clk    : clock, all state updates on posedge
//   rst    : asynchronous active-high reset (aborts any run silently)
//   bus_if : slave side of dsp_mac_sequencer_if (handshake, CE/reset strobes, status)
// Every output is a register except ce_ab, which must follow the accept in the same cycle.
module dsp_mac_sequencer #(
    parameter int unsigned CNT_W      = 8,
    parameter logic [7:0]  OPMODE_ACC = 8'h09
) (
    input  logic                clk,
    input  logic                rst,
    dsp_mac_sequencer_if.slave  bus_if
);
    localparam int unsigned OPMODE_W = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_DRAIN,
        S_FINISH
    } state_e;

    state_e              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    len_q;
    logic                in_ready_q;
    logic                ce_m_q;
    logic                ce_p_q;
    logic                rst_p_q;
    logic                busy_q;
    logic                result_valid_q;
    logic                done_q;
    logic [OPMODE_W-1:0] opmode_q;

    logic                accept_c;
    logic                last_c;

    // in_ready_q is only high in RUN, so in_valid is ignored everywhere else.
    assign accept_c = bus_if.in_valid & in_ready_q;
    // cnt_q stays below len_q while in RUN, so the increment never wraps.
    assign last_c   = accept_c && (CNT_W'(cnt_q + 1'b1) == len_q);

    // Run control, pipeline token shift and registered strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            len_q          <= '0;
            in_ready_q     <= 1'b0;
            ce_m_q         <= 1'b0;
            ce_p_q         <= 1'b0;
            rst_p_q        <= 1'b0;
            busy_q         <= 1'b0;
            result_valid_q <= 1'b0;
            done_q         <= 1'b0;
            opmode_q       <= '0;
        end else begin
            ce_m_q         <= accept_c;
            ce_p_q         <= ce_m_q;
            rst_p_q        <= 1'b0;
            result_valid_q <= 1'b0;
            done_q         <= 1'b0;

            unique case (state_q)
                S_IDLE: begin
                    if (bus_if.start) begin
                        if (bus_if.len != '0) begin
                            len_q    <= bus_if.len;
                            cnt_q    <= '0;
                            state_q  <= S_CLEAR;
                            rst_p_q  <= 1'b1;
                            busy_q   <= 1'b1;
                            opmode_q <= OPMODE_ACC;
                        end else begin
                            done_q   <= 1'b1;
                        end
                    end
                end
                S_CLEAR: begin
                    state_q    <= S_RUN;
                    in_ready_q <= 1'b1;
                end
                S_RUN: begin
                    if (accept_c) begin
                        cnt_q <= CNT_W'(cnt_q + 1'b1);
                        if (last_c) begin
                            state_q    <= S_DRAIN;
                            in_ready_q <= 1'b0;
                        end
                    end
                end
                S_DRAIN: begin
                    // No accepts happen here, so once ce_m is empty ce_p empties on
                    // this edge and P holds the final sum in the next cycle.
                    if (!ce_m_q) begin
                        state_q        <= S_FINISH;
                        result_valid_q <= 1'b1;
                        done_q         <= 1'b1;
                    end
                end
                S_FINISH: begin
                    state_q  <= S_IDLE;
                    busy_q   <= 1'b0;
                    opmode_q <= '0;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus_if.in_ready     = in_ready_q;
    assign bus_if.ce_ab        = accept_c;
    assign bus_if.ce_m         = ce_m_q;
    assign bus_if.ce_p         = ce_p_q;
    assign bus_if.rst_p        = rst_p_q;
    assign bus_if.opmode       = opmode_q;
    assign bus_if.busy         = busy_q;
    assign bus_if.result_valid = result_valid_q;
    assign bus_if.done         = done_q;
endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Self-checking bench for dsp_mac_sequencer with a behavioural DSP48A1 A/B-M-P datapath.
module tb_dsp_mac_sequencer;
    localparam int unsigned CNT_W = 8;
    localparam logic [7:0]  OPM   = 8'h09;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dsp_mac_sequencer_if #(.CNT_W(CNT_W)) bus ();

    dsp_mac_sequencer #(.CNT_W(CNT_W), .OPMODE_ACC(OPM)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_if (bus)
    );

    // Behavioural slice: A/B -> M = A*B -> P = P + M, driven only by the strobes.
    logic [7:0]  a_in, b_in, a_r, b_r;
    logic [15:0] m_r;
    logic [31:0] p_r;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r <= '0; b_r <= '0; m_r <= '0; p_r <= '0;
        end else begin
            if (bus.ce_ab) begin a_r <= a_in; b_r <= b_in; end
            if (bus.ce_m) m_r <= 16'(a_r) * 16'(b_r);
            if (bus.rst_p) p_r <= '0;
            else if (bus.ce_p && bus.opmode == OPM) p_r <= p_r + 32'(m_r);
        end
    end

    int checks   = 0;
    int failures = 0;
    longint unsigned exp_q[$];
    bit vpat[$];
    int          mid_cyc = -1;
    int unsigned mid_len = 0;

    int unsigned r_acc, r_rv_cnt, r_done_cnt, r_rstp_cnt, r_cem_cnt, r_cep_cnt;
    int          r_last_acc, r_rv_cyc, r_done_cyc;
    logic        r_ready_after;
    bit          r_aborted;
    logic [15:0] tr_rstp, tr_ceab, tr_cem, tr_cep, tr_rv, tr_done, tr_busy;

    // Drives one run (start at cycle 0), pushes the expected sum once len pairs have
    // been offered while in_ready, pops and compares on result_valid, and records events.
    task automatic run_mac(input int unsigned n, input int budget, input int unsigned abort_after);
        longint unsigned sum = 0;
        longint unsigned exp;
        int unsigned     sent = 0;
        int              done_at = -1;
        bit              prev_acc = 1'b0;
        r_acc = 0; r_rv_cnt = 0; r_done_cnt = 0; r_rstp_cnt = 0; r_cem_cnt = 0; r_cep_cnt = 0;
        r_last_acc = -1; r_rv_cyc = -1; r_done_cyc = -1; r_ready_after = 1'b1; r_aborted = 1'b0;
        tr_rstp = '0; tr_ceab = '0; tr_cem = '0; tr_cep = '0; tr_rv = '0; tr_done = '0; tr_busy = '0;
        for (int cyc = 0; cyc < budget; cyc++) begin
            @(posedge clk); #1;
            if (abort_after != 0 && r_acc == abort_after) begin
                rst = 1'b1;
                r_aborted = 1'b1;
                return;
            end
            bus.start = (cyc == 0) || (cyc == mid_cyc);
            bus.len   = (cyc == mid_cyc) ? CNT_W'(mid_len) : CNT_W'(n);
            a_in = 8'($urandom);
            b_in = 8'($urandom);
            if (bus.in_ready && vpat.size() != 0) bus.in_valid = vpat.pop_front();
            else bus.in_valid = 1'b1;
            if (bus.in_ready && bus.in_valid && sent < n) begin
                sum += 64'(a_in) * 64'(b_in);
                sent++;
                if (sent == n) exp_q.push_back(sum);
            end
            #1;
            if (bus.ce_ab) begin r_acc++; r_last_acc = cyc; end
            if (prev_acc) r_ready_after = bus.in_ready;
            prev_acc = bus.ce_ab;
            if (bus.rst_p) r_rstp_cnt++;
            if (bus.ce_m)  r_cem_cnt++;
            if (bus.ce_p)  r_cep_cnt++;
            if (bus.result_valid) begin
                r_rv_cnt++;
                r_rv_cyc = cyc;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL sb_result: unexpected result_valid, P=%0d required=no result", p_r);
                end else begin
                    exp = exp_q.pop_front();
                    if (64'(p_r) !== exp) begin
                        failures++;
                        $display("FAIL sb_result: P=%0d required=%0d", p_r, exp);
                    end
                end
            end
            if (bus.done) begin
                r_done_cnt++;
                r_done_cyc = cyc;
                if (done_at < 0) done_at = cyc;
            end
            if (cyc < 16) begin
                tr_rstp[cyc] = bus.rst_p;
                tr_ceab[cyc] = bus.ce_ab;
                tr_cem[cyc]  = bus.ce_m;
                tr_cep[cyc]  = bus.ce_p;
                tr_rv[cyc]   = bus.result_valid;
                tr_done[cyc] = bus.done;
                tr_busy[cyc] = bus.busy;
            end
            if (done_at >= 0 && cyc >= done_at + 2) return;
        end
        checks++;
        failures++;
        $display("FAIL run_timeout: len=%0d no done within %0d cycles", n, budget);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0; bus.len = '0; bus.in_valid = 1'b1;
        a_in = '0; b_in = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bus.in_ready, bus.ce_ab, bus.ce_m, bus.ce_p, bus.rst_p, bus.busy, bus.result_valid, bus.done} !== 8'h00) begin
            failures++;
            $display("FAIL reset_outputs: got %b required 00000000",
                     {bus.in_ready, bus.ce_ab, bus.ce_m, bus.ce_p, bus.rst_p, bus.busy, bus.result_valid, bus.done});
        end
        checks++;
        if (bus.opmode !== 8'h00) begin
            failures++;
            $display("FAIL reset_opmode: got %h required 00", bus.opmode);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        checks++;
        if ({bus.in_ready, bus.ce_ab, bus.busy} !== 3'b000) begin
            failures++;
            $display("FAIL idle_ignores_valid: ready/ce_ab/busy=%b required 000", {bus.in_ready, bus.ce_ab, bus.busy});
        end
    endtask

    task automatic test_back_to_back();
        run_mac(3, 40, 0);
        checks++; if (tr_rstp !== 16'h0002) begin failures++; $display("FAIL b2b_rst_p: got %h required 0002", tr_rstp); end
        checks++; if (tr_ceab !== 16'h001C) begin failures++; $display("FAIL b2b_ce_ab: got %h required 001c", tr_ceab); end
        checks++; if (tr_cem  !== 16'h0038) begin failures++; $display("FAIL b2b_ce_m: got %h required 0038", tr_cem); end
        checks++; if (tr_cep  !== 16'h0070) begin failures++; $display("FAIL b2b_ce_p: got %h required 0070", tr_cep); end
        checks++; if (tr_rv   !== 16'h0080) begin failures++; $display("FAIL b2b_result_valid: got %h required 0080", tr_rv); end
        checks++; if (tr_done !== 16'h0080) begin failures++; $display("FAIL b2b_done: got %h required 0080", tr_done); end
        checks++; if (tr_busy !== 16'h00FE) begin failures++; $display("FAIL b2b_busy: got %h required 00fe", tr_busy); end
        checks++; if (r_acc != 3) begin failures++; $display("FAIL b2b_accepts: got %0d required 3", r_acc); end
    endtask

    task automatic test_bubbles();
        bit pat [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        foreach (pat[i]) vpat.push_back(pat[i]);
        run_mac(4, 60, 0);
        vpat.delete();
        checks++; if (r_acc != 4) begin failures++; $display("FAIL bub_accepts: got %0d required 4", r_acc); end
        checks++; if (r_last_acc != 7) begin failures++; $display("FAIL bub_last_accept: cycle %0d required 7", r_last_acc); end
        checks++; if (r_ready_after !== 1'b0) begin failures++; $display("FAIL bub_ready_drop: in_ready=%b required 0", r_ready_after); end
        checks++; if (r_rv_cyc != 10) begin failures++; $display("FAIL bub_rv_latency: cycle %0d required 10", r_rv_cyc); end
        checks++; if (r_rv_cnt != 1) begin failures++; $display("FAIL bub_rv_count: got %0d required 1", r_rv_cnt); end
    endtask

    task automatic test_zero_len();
        run_mac(0, 20, 0);
        checks++; if (r_done_cnt != 1 || r_done_cyc != 1) begin failures++; $display("FAIL zero_done: count %0d cycle %0d required 1 at 1", r_done_cnt, r_done_cyc); end
        checks++; if (r_rv_cnt != 0) begin failures++; $display("FAIL zero_rv: got %0d required 0", r_rv_cnt); end
        checks++; if (r_acc + r_cem_cnt + r_cep_cnt + r_rstp_cnt != 0) begin
            failures++; $display("FAIL zero_strobes: ce_ab %0d ce_m %0d ce_p %0d rst_p %0d required all 0", r_acc, r_cem_cnt, r_cep_cnt, r_rstp_cnt);
        end
        checks++; if (tr_busy !== 16'h0000) begin failures++; $display("FAIL zero_busy: got %h required 0000", tr_busy); end
    endtask

    task automatic test_start_while_busy();
        mid_cyc = 4;
        mid_len = 2;
        run_mac(5, 60, 0);
        mid_cyc = -1;
        checks++; if (r_acc != 5) begin failures++; $display("FAIL busy_start_accepts: got %0d required 5", r_acc); end
        checks++; if (r_rv_cyc != 9) begin failures++; $display("FAIL busy_start_rv: cycle %0d required 9", r_rv_cyc); end
        checks++; if (r_rv_cnt != 1 || r_done_cnt != 1) begin failures++; $display("FAIL busy_start_pulses: rv %0d done %0d required 1 and 1", r_rv_cnt, r_done_cnt); end
    endtask

    task automatic test_reset_mid();
        int unsigned late_pulses = 0;
        run_mac(5, 40, 2);
        checks++; if (!r_aborted) begin failures++; $display("FAIL midrst_reach: aborted=%0d required 1", r_aborted); end
        #1;
        checks++;
        if ({bus.in_ready, bus.ce_ab, bus.ce_m, bus.ce_p, bus.rst_p, bus.busy, bus.result_valid, bus.done, bus.opmode} !== 16'h0000) begin
            failures++;
            $display("FAIL midrst_outputs: got %h required 0000",
                     {bus.in_ready, bus.ce_ab, bus.ce_m, bus.ce_p, bus.rst_p, bus.busy, bus.result_valid, bus.done, bus.opmode});
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        bus.start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #2;
            if (bus.done || bus.result_valid || bus.busy) late_pulses++;
        end
        checks++; if (late_pulses != 0) begin failures++; $display("FAIL midrst_no_done: %0d active cycles required 0", late_pulses); end
        run_mac(2, 40, 0);
        checks++; if (tr_rstp !== 16'h0002) begin failures++; $display("FAIL fresh_rst_p: got %h required 0002", tr_rstp); end
        checks++; if (tr_ceab !== 16'h000C) begin failures++; $display("FAIL fresh_ce_ab: got %h required 000c", tr_ceab); end
        checks++; if (tr_rv !== 16'h0040 || tr_done !== 16'h0040) begin
            failures++; $display("FAIL fresh_finish: rv %h done %h required 0040 0040", tr_rv, tr_done);
        end
    endtask

    task automatic test_max_len();
        run_mac(255, 400, 0);
        checks++; if (r_acc != 255) begin failures++; $display("FAIL max_accepts: got %0d required 255", r_acc); end
        checks++; if (r_rv_cnt != 1 || r_done_cnt != 1) begin failures++; $display("FAIL max_pulses: rv %0d done %0d required 1 and 1", r_rv_cnt, r_done_cnt); end
        checks++; if (r_rv_cyc != 259) begin failures++; $display("FAIL max_rv_cycle: cycle %0d required 259", r_rv_cyc); end
        checks++; if (r_ready_after !== 1'b0) begin failures++; $display("FAIL max_ready_drop: in_ready=%b required 0", r_ready_after); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_bubbles();
        test_zero_len();
        test_start_while_busy();
        test_reset_mid();
        test_max_len();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL sb_drain: %0d results outstanding required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
